riscv_clint_timer: RTL and testbench

Machine-timer unit of the core-local interruptor (CLINT). Holds the 64-bit `mtime` and `mtimecmp` registers and raises the machine timer interrupt pending line (MTIP) to the CSR unit. It sits directly downstream of the load/store unit and consumes its decoded timer read enable, write enable and register-select outputs. It returns read data to the memory-stage writeback mux, in parallel with the data cache.

---
 rtl/riscv_clint_timer.sv | 125 ++++++++++++
 tb/tb_riscv_clint_timer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_clint_timer.sv
// rtl/riscv_clint_timer.sv - CLINT machine timer: mtime, mtimecmp and the MTIP line to the CSR unit.
// Optional mtime prescaler is built only when RISCV_CLINT_PRESCALER_EN is defined.
module riscv_clint_timer #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic        i_riscv_timer_clk,
   input  logic        i_riscv_timer_rst,
   input  logic        i_riscv_timer_globstall,
   input  logic        i_riscv_timer_wren,
   input  logic        i_riscv_timer_rden,
   input  logic [1:0]  i_riscv_timer_regsel,
   input  logic [1:0]  i_riscv_timer_wsize,
   input  logic [63:0] i_riscv_timer_wdata,
   output logic [63:0] o_riscv_timer_rdata,
   output logic        o_riscv_timer_mtip
);

   localparam logic [1:0] SEL_MTIME    = 2'b01;
   localparam logic [1:0] SEL_MTIMECMP = 2'b10;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   if ((PRESCALE < 1) || (PRESCALE > 65535)) begin : g_bad_prescale
      $error("riscv_clint_timer: PRESCALE must be within 1..65535");
   end

   logic [63:0] mtime_q;
   logic [63:0] mtimecmp_q;
   logic        mtip_q;

   logic        sel_mtime;
   logic        sel_mtimecmp;
   logic        wr_commit;
   logic        wr_mtime;
   logic        wr_mtimecmp;
   logic [63:0] wr_mask;
   logic [63:0] mtime_merged;
   logic [63:0] mtimecmp_merged;
   logic        tick;

   assign sel_mtime    = (i_riscv_timer_regsel == SEL_MTIME);
   assign sel_mtimecmp = (i_riscv_timer_regsel == SEL_MTIMECMP);

   // A stalled store is simply not committed; the LSU keeps presenting it.
   assign wr_commit   = i_riscv_timer_wren & ~i_riscv_timer_globstall;
   assign wr_mtime    = wr_commit & sel_mtime;
   assign wr_mtimecmp = wr_commit & sel_mtimecmp;

   always_comb begin
      wr_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      case (i_riscv_timer_wsize)
         SIZE_BYTE: wr_mask = 64'h0000_0000_0000_00FF;
         SIZE_HALF: wr_mask = 64'h0000_0000_0000_FFFF;
         SIZE_WORD: wr_mask = 64'h0000_0000_FFFF_FFFF;
         default:   wr_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   end

   assign mtime_merged    = (mtime_q    & ~wr_mask) | (i_riscv_timer_wdata & wr_mask);
   assign mtimecmp_merged = (mtimecmp_q & ~wr_mask) | (i_riscv_timer_wdata & wr_mask);

`ifdef RISCV_CLINT_PRESCALER_EN
   localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

   logic [15:0] presc_q;

   assign tick = (presc_q == PRESC_LAST);

   // Writing mtime restarts a full prescale period.
   always_ff @(posedge i_riscv_timer_clk) begin
      if (i_riscv_timer_rst) begin
         presc_q <= 16'd0;
      end else if (wr_mtime || tick) begin
         presc_q <= 16'd0;
      end else begin
         presc_q <= presc_q + 16'd1;
      end
   end
`else
   assign tick = 1'b1;
`endif

   always_ff @(posedge i_riscv_timer_clk) begin
      if (i_riscv_timer_rst) begin
         mtime_q <= 64'd0;
      end else if (wr_mtime) begin
         mtime_q <= mtime_merged;
      end else if (tick) begin
         mtime_q <= mtime_q + 64'd1;
      end
   end

   always_ff @(posedge i_riscv_timer_clk) begin
      if (i_riscv_timer_rst) begin
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (wr_mtimecmp) begin
         mtimecmp_q <= mtimecmp_merged;
      end
   end

   // Compare uses the registered values, so MTIP lags the compare by one cycle.
   always_ff @(posedge i_riscv_timer_clk) begin
      if (i_riscv_timer_rst) begin
         mtip_q <= 1'b0;
      end else begin
         mtip_q <= (mtime_q >= mtimecmp_q);
      end
   end

   always_comb begin
      o_riscv_timer_rdata = 64'd0;
      if (i_riscv_timer_rden) begin
         if (sel_mtime) begin
            o_riscv_timer_rdata = mtime_q;
         end else if (sel_mtimecmp) begin
            o_riscv_timer_rdata = mtimecmp_q;
         end
      end
   end

   assign o_riscv_timer_mtip = mtip_q;

endmodule

// File: tb/tb_riscv_clint_timer.sv
// tb/tb_riscv_clint_timer.sv - scoreboard bench for riscv_clint_timer against a closed-form timer model.
module tb_riscv_clint_timer;

`ifdef RISCV_CLINT_PRESCALER_EN
   localparam int P = 4;
`else
   localparam int P = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        wren = 1'b0;
   logic        rden = 1'b0;
   logic [1:0]  regsel = 2'b00;
   logic [1:0]  wsize = 2'b00;
   logic [63:0] wdata = 64'd0;
   logic [63:0] rdata;
   logic        mtip;

   riscv_clint_timer #(.PRESCALE(P)) dut (
      .i_riscv_timer_clk       (clk),
      .i_riscv_timer_rst       (rst),
      .i_riscv_timer_globstall (stall),
      .i_riscv_timer_wren      (wren),
      .i_riscv_timer_rden      (rden),
      .i_riscv_timer_regsel    (regsel),
      .i_riscv_timer_wsize     (wsize),
      .i_riscv_timer_wdata     (wdata),
      .o_riscv_timer_rdata     (rdata),
      .o_riscv_timer_mtip      (mtip)
   );

   always #5 clk = ~clk;

   logic [64:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   // mtime is base_val plus the number of whole periods elapsed since base_cycle.
   int          n = 0;
   int          base_cycle = 0;
   logic [63:0] base_val = 64'd0;
   logic [63:0] m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
   logic        m_mtip = 1'b0;

   function automatic logic [63:0] model_mtime();
      return base_val + 64'((n - base_cycle) / P);
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                         input logic [1:0] sz);
      int bits;
      logic [63:0] m;
      bits = 8 << sz;
      m = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
      return (old & ~m) | (wd & m);
   endfunction

   task automatic cyc(input logic r, input logic wr, input logic rd, input logic [1:0] sel,
                      input logic [1:0] sz, input logic [63:0] wd, input logic st);
      logic [63:0] cur;
      logic [63:0] exp_rd;
      @(negedge clk);
      rst = r; wren = wr; rden = rd; regsel = sel; wsize = sz; wdata = wd; stall = st;
      cur = model_mtime();
      exp_rd = 64'd0;
      if (rd && sel == 2'b01) exp_rd = cur;
      if (rd && sel == 2'b10) exp_rd = m_cmp;
      exp_q.push_back({m_mtip, exp_rd});
      if (r) begin
         base_val = 64'd0;
         base_cycle = n + 1;
         m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
         m_mtip = 1'b0;
      end else begin
         m_mtip = (cur >= m_cmp);
         if (wr && !st && sel == 2'b01) begin
            base_val = merge(cur, wd, sz);
            base_cycle = n + 1;
         end
         if (wr && !st && sel == 2'b10) m_cmp = merge(m_cmp, wd, sz);
      end
      n++;
   endtask

   task automatic rd_time();
      cyc(1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 64'd0, 1'b0);
   endtask

   task automatic wr_reg(input logic [1:0] sel, input logic [1:0] sz, input logic [63:0] wd);
      cyc(1'b0, 1'b1, 1'b1, sel, sz, wd, 1'b0);
   endtask

   initial begin : monitor
      logic [64:0] e;
      forever begin
         @(negedge clk);
         #2;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rdata !== e[63:0]) begin
               errors++;
               $display("FAIL rdata cycle %0d: got %h expected %h", n - 1, rdata, e[63:0]);
            end
            checks++;
            if (mtip !== e[64]) begin
               errors++;
               $display("FAIL mtip cycle %0d: got %b expected %b", n - 1, mtip, e[64]);
            end
         end
      end
   end

   initial begin : stimulus
      logic [63:0] cur;
      logic        r, wr, rd, st;
      logic [1:0]  sel, sz;
      logic [63:0] wd;
      repeat (2) @(posedge clk);

      // reset state and idle counting
      cyc(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 64'd0, 1'b0);
      for (int i = 0; i < 10; i++) rd_time();
      cyc(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 64'd0, 1'b0);

      // mtimecmp=20: MTIP rises, then a larger compare drops it
      wr_reg(2'b10, 2'b11, 64'd20);
      for (int i = 0; i < 20 * P; i++) rd_time();
      wr_reg(2'b10, 2'b11, 64'd100);
      for (int i = 0; i < 4; i++) rd_time();

      // partial word write keeps upper half
      wr_reg(2'b01, 2'b11, 64'hAAAA_AAAA_0000_0000);
      for (int i = 0; i < 5 * P; i++) rd_time();
      wr_reg(2'b01, 2'b10, 64'hFFFF_0000_1234_5678);
      for (int i = 0; i < 3; i++) rd_time();
      wr_reg(2'b01, 2'b00, 64'h0000_0000_0000_BEEF);
      wr_reg(2'b10, 2'b01, 64'h0000_0000_0000_BEEF);
      cyc(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 64'd0, 1'b0);

      // wrap with mtimecmp all-ones: one-cycle MTIP pulse
      wr_reg(2'b10, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
      wr_reg(2'b01, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE);
      for (int i = 0; i < 4 * P + 2; i++) rd_time();

      // stalled write to mtimecmp and mtime, then release
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 2'b10, 2'b11, 64'd3, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 2'b10, 2'b11, 64'd3, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 2'b01, 2'b11, 64'd50, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 2'b01, 2'b11, 64'd50, 1'b0);
      for (int i = 0; i < 3; i++) rd_time();

      // regsel 00/11 writes and reads are ignored
      cyc(1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 64'd7, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 64'd7, 1'b0);
      rd_time();

      // reset mid-operation beats a concurrent write
      cyc(1'b1, 1'b1, 1'b1, 2'b01, 2'b11, 64'd999, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 64'd0, 1'b0);
      for (int i = 0; i < 3; i++) rd_time();

      // randomized traffic, compare values biased near mtime so MTIP toggles
      for (int i = 0; i < 3000; i++) begin
         cur = model_mtime();
         r   = ($urandom_range(0, 299) == 0);
         wr  = ($urandom_range(0, 99) < 25);
         rd  = ($urandom_range(0, 99) < 70);
         st  = ($urandom_range(0, 99) < 25);
         sel = 2'($urandom_range(0, 3));
         sz  = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       wd = {$urandom, $urandom};
            1:       wd = cur - 64'($urandom_range(0, 8));
            default: wd = cur + 64'($urandom_range(0, 24));
         endcase
         cyc(r, wr, rd, sel, sz, wd, st);
      end

      cyc(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 64'd0, 1'b0);
      repeat (3) @(negedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
